// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU receive and transmit interfaces.
package uart_alu_pkg;

  localparam int unsigned NbDbitDef = 8;
  localparam int unsigned NbOperDef = 6;

  typedef enum logic [1:0] {
    StWaitA  = 2'd0,
    StWaitB  = 2'd1,
    StWaitOp = 2'd2
  } rx_state_e;

endpackage

// File: rtl/interfaz_rx.sv
// Assembles A, B, OP byte frames from the UART receiver into one ALU operand/operator set,
// with an inter-byte timeout and an operator range check.
module interfaz_rx
  import uart_alu_pkg::*;
#(
  parameter int unsigned NB_DBIT = NbDbitDef,
  parameter int unsigned NB_OPER = NbOperDef,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic        [NB_DBIT-1:0] i_data,
  input  logic                      i_rx_done,
  output logic signed [NB_DBIT-1:0] o_dato_a,
  output logic signed [NB_DBIT-1:0] o_dato_b,
  output logic        [NB_OPER-1:0] o_operador,
  output logic                      o_alu_valid,
  output logic                      o_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  rx_state_e state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NB_DBIT-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [NB_DBIT-1:0] dato_a_q, dato_a_d, dato_b_q, dato_b_d;
  logic [NB_OPER-1:0] oper_q, oper_d;
  logic               valid_q, valid_d, error_q, error_d;
  logic               op_ok;
  logic               timed_out;

  assign op_ok     = (i_data[NB_DBIT-1:NB_OPER] == '0);
  assign timed_out = (cnt_q == CntLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    oper_d   = oper_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;

    unique case (state_q)
      StWaitA: begin
        if (i_rx_done) begin
          sh_a_d  = i_data;
          cnt_d   = '0;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (i_rx_done) begin
          sh_b_d  = i_data;
          cnt_d   = '0;
          state_d = StWaitOp;
        end else if (timed_out) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = StWaitA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitOp: begin
        if (i_rx_done) begin
          cnt_d   = '0;
          state_d = StWaitA;
          if (op_ok) begin
            dato_a_d = sh_a_q;
            dato_b_d = sh_b_q;
            oper_d   = i_data[NB_OPER-1:0];
            valid_d  = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else if (timed_out) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = StWaitA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StWaitA;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= StWaitA;
      cnt_q    <= '0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      dato_a_q <= '0;
      dato_b_q <= '0;
      oper_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
      oper_q   <= oper_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign o_dato_a    = dato_a_q;
  assign o_dato_b    = dato_b_q;
  assign o_operador  = oper_q;
  assign o_alu_valid = valid_q;
  assign o_error     = error_q;

endmodule

// File: tb/tb_interfaz_rx.sv
// Directed and randomized byte streams checked cycle by cycle against a frame-level model.
module tb_interfaz_rx;

  localparam int unsigned TO = 20;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic        [7:0] i_data = 8'h00;
  logic              i_rx_done = 1'b0;
  logic signed [7:0] o_dato_a, o_dato_b;
  logic        [5:0] o_operador;
  logic              o_alu_valid, o_error;

  int compared = 0;
  int mismatched = 0;

  // Frame-level reference: bytes collected so far, idle cycles since the last byte.
  logic [7:0] fb [2];
  int         nb = 0;
  int         idle = 0;
  logic [7:0] exp_a = 8'h00, exp_b = 8'h00;
  logic [5:0] exp_op = 6'h00;
  logic       exp_v = 1'b0, exp_e = 1'b0;

  interfaz_rx #(
    .NB_DBIT(8),
    .NB_OPER(6),
    .TIMEOUT(TO)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_rx_done  (i_rx_done),
    .o_dato_a   (o_dato_a),
    .o_dato_b   (o_dato_b),
    .o_operador (o_operador),
    .o_alu_valid(o_alu_valid),
    .o_error    (o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %02h expected %02h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string step);
    chk({step, ".dato_a"}, o_dato_a, exp_a);
    chk({step, ".dato_b"}, o_dato_b, exp_b);
    chk({step, ".operador"}, {2'b00, o_operador}, {2'b00, exp_op});
    chk({step, ".alu_valid"}, {7'd0, o_alu_valid}, {7'd0, exp_v});
    chk({step, ".error"}, {7'd0, o_error}, {7'd0, exp_e});
  endtask

  task automatic model_step(input logic rx, input logic [7:0] d);
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (rx) begin
      idle = 0;
      if (nb < 2) begin
        fb[nb] = d;
        nb++;
      end else begin
        nb = 0;
        if (d[7:6] == 2'b00) begin
          exp_a  = fb[0];
          exp_b  = fb[1];
          exp_op = d[5:0];
          exp_v  = 1'b1;
        end else begin
          exp_e = 1'b1;
        end
      end
    end else if (nb > 0) begin
      idle++;
      if (idle == TO) begin
        exp_e = 1'b1;
        nb    = 0;
        idle  = 0;
      end
    end
  endtask

  // One clock: present inputs, take the edge, sample 1 time unit later.
  task automatic cycle(input string step, input logic rx, input logic [7:0] d);
    i_rx_done = rx;
    i_data    = d;
    @(posedge i_clk);
    #1;
    model_step(rx, d);
    chk_all(step);
  endtask

  task automatic idle_cycles(input string step, input int n);
    for (int k = 0; k < n; k++) cycle(step, 1'b0, 8'($urandom));
  endtask

  task automatic do_reset(input string step);
    i_rx_done = 1'b0;
    i_rst     = 1'b0;
    #1;
    nb = 0; idle = 0;
    exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00; exp_v = 1'b0; exp_e = 1'b0;
    chk_all(step);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    int         r;
    #1;
    chk_all("reset");
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    cycle("idle0", 1'b0, 8'h00);

    // Basic frame, then a back-to-back frame.
    cycle("f1a", 1'b1, 8'h04);
    cycle("f1b", 1'b1, 8'h02);
    cycle("f1op", 1'b1, 8'h20);
    cycle("f2a", 1'b1, 8'h06);
    cycle("f2b", 1'b1, 8'h03);
    cycle("f2op", 1'b1, 8'h22);
    cycle("f2post", 1'b0, 8'h00);

    // Timeout after byte A, then recovery.
    cycle("toa", 1'b1, 8'h10);
    idle_cycles("towait", TO + 2);
    cycle("f3a", 1'b1, 8'h01);
    cycle("f3b", 1'b1, 8'h01);
    cycle("f3op", 1'b1, 8'h20);

    // Byte in the valid cycle becomes byte A of the next frame.
    cycle("f4a", 1'b1, 8'h09);
    cycle("f4b", 1'b1, 8'h85);
    cycle("f4op", 1'b1, 8'h3f);

    // Bad operator, then a byte in the error cycle.
    cycle("bada", 1'b1, 8'h05);
    cycle("badb", 1'b1, 8'h05);
    cycle("badop", 1'b1, 8'hc0);
    cycle("f5a", 1'b1, 8'hf0);
    cycle("f5b", 1'b1, 8'h7f);
    idle_cycles("f5gap", TO - 1);
    cycle("f5op", 1'b1, 8'h01);

    // Timeout in WAIT_OP exactly at the limit, and rx_done winning on the last cycle.
    cycle("toopa", 1'b1, 8'h11);
    cycle("toopb", 1'b1, 8'h22);
    idle_cycles("toopwait", TO);
    cycle("edgea", 1'b1, 8'h33);
    idle_cycles("edgegap", TO - 1);
    cycle("edgeb", 1'b1, 8'h44);
    cycle("edgeop", 1'b1, 8'h05);

    // Reset mid-frame.
    cycle("rsta", 1'b1, 8'h07);
    cycle("rstb", 1'b1, 8'h08);
    do_reset("midreset");
    cycle("rstidle", 1'b0, 8'h00);
    cycle("f6a", 1'b1, 8'h02);
    cycle("f6b", 1'b1, 8'h03);
    cycle("f6op", 1'b1, 8'h20);
    cycle("f6post", 1'b0, 8'h00);

    // Randomized traffic with occasional long gaps and resets.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 90) begin
        d = 8'($urandom);
        if ($urandom_range(0, 3) != 0) d[7:6] = 2'b00;
        cycle("rnd_byte", 1'b1, d);
      end else if (r < 96) begin
        idle_cycles("rnd_gap", int'($urandom_range(TO - 2, TO + 2)));
      end else if (r == 199) begin
        do_reset("rnd_reset");
      end else begin
        cycle("rnd_idle", 1'b0, 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/interfaz_rx.md
INTERFAZ_RX -- requirements
Module: interfaz_rx

Interface
REQ-001 SHALL have parameter NB_DBIT, default 8, width of the UART byte and of ALU operands.
REQ-002 SHALL have parameter NB_OPER, default 6, width of the ALU operator code.
REQ-003 SHALL have parameter TIMEOUT, default 100000, inter-byte timeout in i_clk cycles (minimum 2).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  rising-edge system clock.
REQ-006 i_rst  input  1  asynchronous active-low reset.
REQ-007 i_data  input  NB_DBIT  byte from UART receiver, valid only while i_rx_done=1.
REQ-008 i_rx_done  input  1  one-cycle pulse, byte available on i_data.
REQ-009 o_dato_a  output  NB_DBIT signed  operand A to ALU.
REQ-010 o_dato_b  output  NB_DBIT signed  operand B to ALU.
REQ-011 o_operador  output  NB_OPER  ALU operator code.
REQ-012 o_alu_valid  output  1  one-cycle pulse, new operand/operator set presented.
REQ-013 o_error  output  1  one-cycle pulse, frame discarded (timeout or bad operator).

Function
REQ-014 SHALL assemble frames of three bytes in order A, B, OP; FSM states WAIT_A, WAIT_B, WAIT_OP.
REQ-015 WAIT_A: on i_rx_done, SHALL capture i_data into internal shadow A, go to WAIT_B.
REQ-016 WAIT_B: on i_rx_done, SHALL capture shadow B, go to WAIT_OP.
REQ-017 WAIT_OP: on i_rx_done with i_data[NB_DBIT-1:NB_OPER]==0, SHALL, on the next edge, load o_dato_a/o_dato_b from shadows, o_operador from i_data[NB_OPER-1:0], pulse o_alu_valid for exactly one cycle, return to WAIT_A.
REQ-018 WAIT_OP: on i_rx_done with any nonzero bit in i_data[NB_DBIT-1:NB_OPER], SHALL discard the frame, pulse o_error one cycle, return to WAIT_A, leave outputs unchanged.
REQ-019 Latency: o_alu_valid SHALL be high in the cycle after the i_rx_done carrying OP.
REQ-020 o_dato_a, o_dato_b, o_operador SHALL change only together with o_alu_valid and hold otherwise.
REQ-021 A byte arriving in the cycle o_alu_valid or o_error is high SHALL be accepted as byte A of the next frame; no byte lost with back-to-back pulses.
REQ-022 Timeout counter SHALL clear on every accepted byte and count each cycle in WAIT_B/WAIT_OP without i_rx_done.
REQ-023 When the counter reaches TIMEOUT-1 in WAIT_B/WAIT_OP without i_rx_done, SHALL pulse o_error next cycle, return to WAIT_A, leave outputs unchanged.
REQ-024 i_rx_done in the timeout cycle SHALL win: byte accepted, no timeout.
REQ-025 Counter SHALL not count in WAIT_A.
REQ-026 o_alu_valid and o_error SHALL never be high in the same cycle.

Reset
REQ-027 i_rst=0 SHALL immediately force state WAIT_A, counter 0, shadows 0, o_dato_a=0, o_dato_b=0, o_operador=0, o_alu_valid=0, o_error=0.
REQ-028 Reset mid-frame SHALL abandon the partial frame with no o_alu_valid or o_error.

Structure
REQ-029 NB_DBIT/NB_OPER defaults and state encodings SHALL live in shared package uart_alu_pkg, used also by interfaz_tx.
REQ-030 Counter width SHALL be $clog2(TIMEOUT).
REQ-031 Single module, no sub-modules.

Verification
REQ-032 Bytes 0x04, 0x02, 0x20 -> one cycle after third pulse o_alu_valid=1, o_dato_a=4, o_dato_b=2, o_operador=6'b100000.
REQ-033 Then 0x06, 0x03, 0x22 on consecutive cycles -> one o_alu_valid, a=6, b=3, op=6'b100010; ALU result 3.
REQ-034 Byte 0x10, then no pulse for TIMEOUT cycles -> o_error pulse, outputs unchanged; next 0x01,0x01,0x20 -> valid frame a=1,b=1.
REQ-035 Bytes 0x05, 0x05, 0xC0 -> o_error, no o_alu_valid, outputs keep prior values.
REQ-036 Bytes 0x07, 0x08, reset pulse, then 0x02, 0x03, 0x20 -> all outputs 0 after reset, then a=2, b=3, op=0x20.
REQ-037 i_rx_done in the o_alu_valid cycle with 0x09 -> accepted as A of next frame.
